jk_reg_bank: RTL and testbench
==============================

JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the number of JK bits (legal range 2..32).
REQ-002 Parameter RST_VAL, default 0, SHALL be the WIDTH-bit value loaded into q on reset.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst, input, 1: reset, synchronous, active-low; it SHALL act only at a rising clk edge.
REQ-005 Port en, input, 1: bank enable; when 0, the bank holds q.
REQ-006 Port mode, input, 2: operating mode (00 JK, 01 count up, 10 count down, 11 load).
REQ-007 Port j, input, WIDTH: per-bit J inputs; also the load data in mode 11.
REQ-008 Port k, input, WIDTH: per-bit K inputs; ignored outside mode 00.
REQ-009 Port q, output, WIDTH: registered bank state.
REQ-010 Port tc, output, 1: registered terminal-count pulse.
REQ-011 Port chg, output, 1: registered flag; 1 when the last edge changed q.

Function
REQ-012 mode 00, per bit i: j/k = 00 SHALL hold, 01 SHALL clear, 10 SHALL set, and 11 SHALL toggle q[i]; bits SHALL be independent.
REQ-013 mode 01 SHALL compute q <= q+1 mod 2^WIDTH, i.e. bit i toggles iff q[i-1:0] are all 1; j and k SHALL be ignored.
REQ-014 mode 10 SHALL compute q <= q-1 mod 2^WIDTH, i.e. bit i toggles iff q[i-1:0] are all 0; j and k SHALL be ignored.
REQ-015 mode 11 SHALL compute q <= j; k SHALL be ignored.
REQ-016 en=0 SHALL hold q regardless of mode, j and k, and SHALL drive tc <= 0 and chg <= 0 at that edge.
REQ-017 Latency: q SHALL reflect inputs sampled at edge N immediately after edge N (one-cycle registered, no extra pipeline).
REQ-018 A mode change SHALL take effect at the first edge that samples the new mode; no state is kept across modes other than q.
REQ-019 tc SHALL be set to 1 at an edge where en=1 and either (mode=01 and q=all-ones) or (mode=10 and q=0); otherwise tc SHALL be set to 0.
REQ-020 As a result of REQ-019, tc SHALL be high during exactly the cycle in which q shows the wrapped value (0 for up, all-ones for down).
REQ-021 tc SHALL never assert in modes 00 or 11, including when a JK toggle or load produces a wrap-like pattern.
REQ-022 chg SHALL be set to 1 at an edge where en=1 and the next q differs from the current q in any bit; otherwise chg SHALL be set to 0.
REQ-023 In mode 11, loading a value equal to the current q SHALL give chg=0; in mode 00, j=k=0 on all bits SHALL give chg=0.
REQ-024 tc and chg SHALL be coincident with the q update that caused them, both being one-cycle pulses unless their condition persists.

Reset
REQ-025 At a rising edge with rst=0: q SHALL be set to RST_VAL, and tc and chg SHALL be set to 0, overriding en, mode, j and k.
REQ-026 rst going low between edges SHALL have no effect until the next rising edge; a mid-count reset SHALL discard the count without a tc pulse.
REQ-027 At the first edge with rst=1, normal operation SHALL resume from RST_VAL with the inputs present at that edge.
REQ-028 There SHALL be no asynchronous path from rst to q, tc or chg.

Verification (WIDTH=4, RST_VAL=0 unless stated)
REQ-029 Reset/JK: rst=0 for 1 edge, then rst=1 with mode=00 and j,k = 0000,0000 / 0000,1111 / 1010,0000 / 1111,1111 / 1111,1111 -> q = 0000, 0000, 1010, 0101, 1010; chg = 0, 0, 1, 1, 1.
REQ-030 Up-count wrap: load 1110 (mode 11), then mode 01 for 3 edges -> q = 1111, 0000, 0001; tc = 0, 1, 0.
REQ-031 Down-count wrap: from q=0001, mode 10 for 3 edges -> q = 0000, 1111, 1110; tc = 0, 1, 0.
REQ-032 Enable/hold: q=0101 with en=0, mode=01 for 4 edges -> q stays 0101, tc=0, chg=0; en=1 on the next edge -> q=0110, chg=1.
REQ-033 Mid-operation reset: count up to 0111, assert rst=0 at the next edge while en=1 and mode=01 -> q=0000, tc=0, chg=0; release rst -> q=0001 at the next edge.
REQ-034 Parameter check: with WIDTH=8 and RST_VAL=8'hFE, reset then mode 01 for 2 edges -> q = FE, FF, 00; tc=1 only with 00.

Source files
------------

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops sharing one clock, with counter and load modes.
// Registered terminal-count and change flags accompany every q update.
module jk_reg_bank #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             chg
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             chg_q, chg_d;

  // Per-bit JK characteristic equation: Q+ = J & ~Q | ~K & Q.
  function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] jv,
                                               input logic [WIDTH-1:0] kv);
    return (jv & ~cur) | (~kv & cur);
  endfunction

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    chg_d = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK:   q_d = jk_next(q_q, j, k);
        MODE_UP:   q_d = q_q + ONE;
        MODE_DOWN: q_d = q_q - ONE;
        MODE_LOAD: q_d = j;
        default:   q_d = q_q;
      endcase
      // Terminal count flags the edge that produces the wrapped value.
      tc_d  = ((mode == MODE_UP) && (&q_q)) || ((mode == MODE_DOWN) && !(|q_q));
      chg_d = (q_d != q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q   <= RST_VAL;
      tc_q  <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      chg_q <= chg_d;
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign chg = chg_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Bench for jk_reg_bank: 4-bit and 8-bit instances checked against an
// arithmetic model every cycle, plus directed literal expectations.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic [3:0] j4, k4, q4;
  logic [7:0] j8, k8, q8;
  logic       tc4, chg4, tc8, chg8;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  int mq4 = 0, mq8 = 0;
  bit mtc4 = 0, mchg4 = 0, mtc8 = 0, mchg8 = 0;

  jk_reg_bank #(.WIDTH(4), .RST_VAL(4'h0)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .j(j4), .k(k4), .q(q4), .tc(tc4), .chg(chg4)
  );

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hFE)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .j(j8), .k(k8), .q(q8), .tc(tc8), .chg(chg8)
  );

  always #5 clk = ~clk;

  // Reference rules written as plain integer arithmetic.
  function automatic int model_next(input int cur, input int w, input bit e,
                                    input int md, input int jv, input int kv);
    int modulus;
    int r;
    modulus = 1 << w;
    if (!e) return cur;
    case (md)
      0: begin
        r = 0;
        for (int i = 0; i < w; i++) begin
          int b, jb, kb;
          b  = (cur >> i) & 1;
          jb = (jv >> i) & 1;
          kb = (kv >> i) & 1;
          if (jb == 1 && kb == 1) b = 1 - b;
          else if (jb == 1)       b = 1;
          else if (kb == 1)       b = 0;
          r = r + (b << i);
        end
        return r;
      end
      1:       return (cur + 1) % modulus;
      2:       return (cur + modulus - 1) % modulus;
      default: return jv;
    endcase
  endfunction

  function automatic bit model_tc(input int cur, input int w, input bit e, input int md);
    return e && ((md == 1 && cur == (1 << w) - 1) || (md == 2 && cur == 0));
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mq4 <= 0;   mtc4 <= 1'b0; mchg4 <= 1'b0;
      mq8 <= 254; mtc8 <= 1'b0; mchg8 <= 1'b0;
    end else begin
      mq4   <= model_next(mq4, 4, en, int'(mode), int'(j4), int'(k4));
      mtc4  <= model_tc(mq4, 4, en, int'(mode));
      mchg4 <= (model_next(mq4, 4, en, int'(mode), int'(j4), int'(k4)) != mq4);
      mq8   <= model_next(mq8, 8, en, int'(mode), int'(j8), int'(k8));
      mtc8  <= model_tc(mq8, 8, en, int'(mode));
      mchg8 <= (model_next(mq8, 8, en, int'(mode), int'(j8), int'(k8)) != mq8);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("model_q4",   32'(q4),   32'(mq4));
      check("model_tc4",  32'(tc4),  32'(mtc4));
      check("model_chg4", 32'(chg4), 32'(mchg4));
      check("model_q8",   32'(q8),   32'(mq8));
      check("model_tc8",  32'(tc8),  32'(mtc8));
      check("model_chg8", 32'(chg8), 32'(mchg8));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit e, input logic [1:0] m,
                       input logic [3:0] jv, input logic [3:0] kv);
    rst = r; en = e; mode = m; j4 = jv; k4 = kv; j8 = 8'h00; k8 = 8'h00;
  endtask

  task automatic expect4(input string name, input logic [3:0] eq,
                         input bit etc, input bit echg);
    check({name, "_q"},   32'(q4),   32'(eq));
    check({name, "_tc"},  32'(tc4),  32'(etc));
    check({name, "_chg"}, 32'(chg4), 32'(echg));
  endtask

  logic [3:0] jk_j[5] = '{4'h0, 4'h0, 4'hA, 4'hF, 4'hF};
  logic [3:0] jk_k[5] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'hF};
  logic [3:0] jk_q[5] = '{4'h0, 4'h0, 4'hA, 4'h5, 4'hA};
  bit         jk_c[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    drive(1'b0, 1'b1, 2'b01, 4'hF, 4'hF);
    tick();
    expect4("reset", 4'h0, 1'b0, 1'b0);
    check("reset_q8", 32'(q8), 32'h0FE);
    check_en = 1'b1;

    // JK truth table from reset.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'b00, jk_j[i], jk_k[i]);
      tick();
      expect4("jk", jk_q[i], 1'b0, jk_c[i]);
    end

    // Up-count wrap.
    drive(1'b1, 1'b1, 2'b11, 4'hE, 4'h0); tick();
    drive(1'b1, 1'b1, 2'b01, 4'h3, 4'h5);
    tick(); expect4("up0", 4'hF, 1'b0, 1'b1);
    tick(); expect4("up1", 4'h0, 1'b1, 1'b1);
    tick(); expect4("up2", 4'h1, 1'b0, 1'b1);

    // Down-count wrap from 0001.
    drive(1'b1, 1'b1, 2'b10, 4'h6, 4'h9);
    tick(); expect4("dn0", 4'h0, 1'b0, 1'b1);
    tick(); expect4("dn1", 4'hF, 1'b1, 1'b1);
    tick(); expect4("dn2", 4'hE, 1'b0, 1'b1);

    // Enable hold.
    drive(1'b1, 1'b1, 2'b11, 4'h5, 4'h0); tick();
    drive(1'b1, 1'b0, 2'b01, 4'hF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick(); expect4("hold", 4'h5, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
    tick(); expect4("hold_rel", 4'h6, 1'b0, 1'b1);

    // Mid-count reset.
    tick(); expect4("mid_cnt", 4'h7, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
    tick(); expect4("mid_rst", 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
    tick(); expect4("mid_rel", 4'h1, 1'b0, 1'b1);

    // No tc on wrap-like patterns in JK and load modes; equal load gives chg=0.
    drive(1'b1, 1'b1, 2'b11, 4'hF, 4'h0);
    tick(); expect4("ld_f", 4'hF, 1'b0, 1'b1);
    tick(); expect4("ld_eq", 4'hF, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'b00, 4'hF, 4'hF);
    tick(); expect4("jk_wrap", 4'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'b11, 4'hF, 4'h3);
    tick(); expect4("ld_wrap", 4'hF, 1'b0, 1'b1);

    // 8-bit instance with non-zero reset value.
    drive(1'b0, 1'b1, 2'b00, 4'h0, 4'h0);
    tick();
    check("w8_rst_q", 32'(q8), 32'h0FE);
    check("w8_rst_tc", 32'(tc8), 32'h0);
    drive(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
    tick();
    check("w8_up0_q", 32'(q8), 32'h0FF);
    check("w8_up0_tc", 32'(tc8), 32'h0);
    tick();
    check("w8_up1_q", 32'(q8), 32'h000);
    check("w8_up1_tc", 32'(tc8), 32'h1);

    // Randomized traffic, checked by the per-cycle compare process.
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 24) != 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      j4   = 4'($urandom);
      k4   = 4'($urandom);
      j8   = 8'($urandom);
      k8   = 8'($urandom);
      tick();
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
